// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-SPRAM arbiter: FSM encoding, default geometry,
// and the byte-mask to SPRAM nibble-mask expansion.
package dmem_arb_pkg;

  localparam int          DEF_ADDR_W    = 14;
  localparam logic [31:0] DEF_BASE_ADDR = 32'h0000_1000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } arb_state_e;

  // Byte i of the 32-bit word owns nibble-mask bits 2i+1:2i (two nibbles per byte).
  function automatic logic [7:0] expand_mask(input logic [3:0] wmask);
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      m[2*i +: 2] = {2{wmask[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester arbiter producing a one-hot grant. Round robin by default;
// define DMEM_ARB_FIXED_PRIO_EN to make requester 0 win every tie.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

`ifdef DMEM_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    grant = 2'b00;
    if (req[0])      grant = 2'b01;
    else if (req[1]) grant = 2'b10;
  end
`else
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // On a tie, hand the port to whoever did not have it last.
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Sequencer/arbiter sharing the 32-bit data SPRAM pair between the CPU (m0) and a
// secondary master (m1). Optional build macro: DMEM_ARB_FIXED_PRIO_EN (m0 wins ties).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int          ADDR_W    = DEF_ADDR_W,
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int          DATA_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  // Handshake: a requester raises mX_req with a stable payload and holds both until it
  // samples mX_ack=1 (a one-cycle pulse); it drops req on that same edge.
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [31:0]       m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [3:0]        m0_wmask,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ack,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [31:0]       m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [3:0]        m1_wmask,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ack,
  output logic              m1_err,
  output logic              cpu_stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [7:0]        mem_mask,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_rdata,
  output arb_state_e        state_dbg
);

  arb_state_e        state, state_nxt;
  logic [1:0]        grant;
  logic              last_grant;
  logic              txn_m;
  logic              txn_we;
  logic              txn_in_range;
  logic [ADDR_W-1:0] txn_addr;
  logic [DATA_W-1:0] txn_wdata;
  logic [3:0]        txn_wmask;

  logic              sel_we;
  logic [31:0]       sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [3:0]        sel_wmask;
  logic [31:0]       sel_off;
  logic              sel_in_range;
  logic [1:0]        unused_off_lsb;

  rr_arbiter2 u_arb (
    .req        ({m1_req, m0_req}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign sel_we    = grant[1] ? m1_we    : m0_we;
  assign sel_addr  = grant[1] ? m1_addr  : m0_addr;
  assign sel_wdata = grant[1] ? m1_wdata : m0_wdata;
  assign sel_wmask = grant[1] ? m1_wmask : m0_wmask;

  // Window check: anything below BASE_ADDR or with offset bits above the word index is out.
  assign sel_off        = sel_addr - BASE_ADDR;
  assign sel_in_range   = (sel_addr >= BASE_ADDR) && (sel_off[31:ADDR_W+2] == '0);
  assign unused_off_lsb = sel_off[1:0];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|grant) state_nxt = sel_in_range ? ACCESS : DONE;
      ACCESS:  state_nxt = txn_we ? DONE : CAPTURE;
      CAPTURE: state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      txn_m        <= 1'b0;
      txn_we       <= 1'b0;
      txn_in_range <= 1'b0;
      txn_addr     <= '0;
      txn_wdata    <= '0;
      txn_wmask    <= '0;
      m0_rdata     <= '0;
      m1_rdata     <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && (|grant)) begin
        txn_m        <= grant[1];
        last_grant   <= grant[1];
        txn_we       <= sel_we;
        txn_in_range <= sel_in_range;
        txn_addr     <= sel_off[ADDR_W+1:2];
        txn_wdata    <= sel_wdata;
        txn_wmask    <= sel_wmask;
        // Out-of-window reads never reach the SPRAM; they return zero.
        if (!sel_in_range && !sel_we) begin
          if (grant[1]) m1_rdata <= '0;
          else          m0_rdata <= '0;
        end
      end
      if (state == CAPTURE) begin
        if (txn_m) m1_rdata <= mem_rdata;
        else       m0_rdata <= mem_rdata;
      end
    end
  end

  assign mem_addr  = txn_addr;
  assign mem_wdata = txn_wdata;
  assign mem_mask  = expand_mask(txn_wmask);
  assign mem_wren  = (state == ACCESS) && txn_we;

  assign m0_ack    = (state == DONE) && !txn_m;
  assign m1_ack    = (state == DONE) &&  txn_m;
  assign m0_err    = m0_ack && !txn_in_range;
  assign m1_err    = m1_ack && !txn_in_range;
  assign cpu_stall = m0_req & ~m0_ack;
  assign state_dbg = state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: behavioural SPRAM pair, per-master expected queues,
// latency / write-strobe / round-robin / reset checks.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] TOP  = 32'h0001_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wmask, m1_wmask;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ack, m0_err, m1_ack, m1_err, cpu_stall;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [7:0]  mem_mask;
  logic        mem_wren;
  arb_state_e  state_dbg;

  logic        ram_clr;
  logic [31:0] ram   [0:16383];
  logic [31:0] model [0:16383];

  // {is_read, err, rdata}
  logic [33:0] exp_q0[$];
  logic [33:0] exp_q1[$];
  logic [31:0] last_rd0, last_rd1;
  int          tb_last;
  int          n_checks = 0;
  int          n_fail   = 0;

  dmem_arbiter dut (
    .clk(clk), .reset(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wmask(m0_wmask), .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wmask(m1_wmask), .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
    .cpu_stall(cpu_stall), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_mask(mem_mask), .mem_wren(mem_wren), .mem_rdata(mem_rdata),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset / SPRAM model ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 16384; i++) ram[i] <= '0;
    end else begin
      if (mem_wren) begin
        for (int n = 0; n < 8; n++)
          if (mem_mask[n]) ram[mem_addr][4*n +: 4] <= mem_wdata[4*n +: 4];
      end
      mem_rdata <= ram[mem_addr];
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_ack(input int m);
    logic [33:0] e;
    logic [31:0] rd;
    logic        er, other;
    rd    = (m == 0) ? m0_rdata : m1_rdata;
    er    = (m == 0) ? m0_err   : m1_err;
    other = (m == 0) ? m1_ack   : m0_ack;
    chk("other_ack_low", other, 1'b0);
    if ((m == 0 && exp_q0.size() == 0) || (m == 1 && exp_q1.size() == 0)) begin
      chk("unexpected_ack", 1'b1, 1'b0);
    end else begin
      e = (m == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      chk("ack_err", er, e[32]);
      if (e[33]) begin
        chk("read_data", rd, e[31:0]);
        if (m == 0) last_rd0 = e[31:0]; else last_rd1 = e[31:0];
      end else begin
        chk("rdata_hold", rd, (m == 0) ? last_rd0 : last_rd1);
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (m0_ack) check_ack(0);
    if (m1_ack) check_ack(1);
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input int m, input logic req, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wmask);
    if (m == 0) begin
      m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_wmask = wmask;
    end else begin
      m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_wmask = wmask;
    end
  endtask

  function automatic logic addr_ok(input logic [31:0] addr);
    return (addr >= BASE) && (addr < TOP);
  endfunction

  function automatic logic [13:0] word_of(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE;
    return off[15:2];
  endfunction

  task automatic txn(input int m, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] wmask);
    logic        in_rng, got;
    logic [13:0] word;
    logic [31:0] exp_rd;
    logic [7:0]  exp_mask;
    int          exp_lat, n, wren_cnt;
    in_rng  = addr_ok(addr);
    word    = word_of(addr);
    exp_lat = !in_rng ? 1 : (we ? 2 : 3);
    for (int i = 0; i < 4; i++) exp_mask[2*i +: 2] = wmask[i] ? 2'b11 : 2'b00;
    exp_rd = (!we && in_rng) ? model[word] : 32'h0;
    if (m == 0) exp_q0.push_back({!we, !in_rng, exp_rd});
    else        exp_q1.push_back({!we, !in_rng, exp_rd});
    if (we && in_rng)
      for (int i = 0; i < 4; i++) if (wmask[i]) model[word][8*i +: 8] = wdata[8*i +: 8];
    drive(m, 1'b1, we, addr, wdata, wmask);
    #1;
    if (m == 0) chk("stall_on_req", cpu_stall, 1'b1);
    n = 0; wren_cnt = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(posedge clk); #1; n++;
      // Payload is latched at grant: scramble it to prove later changes are ignored.
      if (n == 1) drive(m, 1'b1, ~we, $urandom, $urandom, 4'($urandom_range(0, 15)));
      if (mem_wren) begin
        wren_cnt++;
        chk("mem_addr", mem_addr, word);
        chk("mem_mask", mem_mask, exp_mask);
        chk("mem_wdata", mem_wdata, wdata);
      end
      got = (m == 0) ? m0_ack : m1_ack;
      if (m == 0) chk("cpu_stall", cpu_stall, !got);
    end
    chk("ack_latency", n, exp_lat);
    chk("wren_count", wren_cnt, (we && in_rng) ? 1 : 0);
    @(posedge clk); #1;
    drive(m, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tb_last = m;
  endtask

  task automatic both_reads(input logic [31:0] a0, input logic [31:0] a1);
    int first, exp_first, n;
    bit d0, d1, p0, p1;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    exp_first = 0;
`else
    exp_first = (tb_last == 1) ? 0 : 1;
`endif
    exp_q0.push_back({1'b1, 1'b0, model[word_of(a0)]});
    exp_q1.push_back({1'b1, 1'b0, model[word_of(a1)]});
    drive(0, 1'b1, 1'b0, a0, 32'h0, 4'h0);
    drive(1, 1'b1, 1'b0, a1, 32'h0, 4'h0);
    first = -1; n = 0; d0 = 0; d1 = 0; p0 = 0; p1 = 0;
    while (!(d0 && d1) && n < 40) begin
      @(posedge clk); #1; n++;
      if (p0) begin m0_req = 1'b0; p0 = 0; end
      if (p1) begin m1_req = 1'b0; p1 = 0; end
      if (m0_ack && !d0) begin d0 = 1; p0 = 1; if (first < 0) first = 0; end
      if (m1_ack && !d1) begin d1 = 1; p1 = 1; if (first < 0) first = 1; end
    end
    @(posedge clk); #1;
    m0_req = 1'b0; m1_req = 1'b0;
    chk("rr_first_grant", first, exp_first);
    chk("rr_both_done", {d0, d1}, 2'b11);
    tb_last = 1 - exp_first;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] a, d;
    logic [3:0]  wm;
    rst = 1'b1; ram_clr = 1'b1;
    last_rd0 = '0; last_rd1 = '0; tb_last = 1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    for (int i = 0; i < 16384; i++) model[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", state_dbg, IDLE);
    chk("rst_acks", {m0_ack, m1_ack, m0_err, m1_err}, 4'h0);
    chk("rst_mem", {mem_wren, mem_addr, mem_wdata, mem_mask}, '0);
    chk("rst_rdata", {m0_rdata, m1_rdata}, 64'h0);
    chk("rst_stall", cpu_stall, 1'b0);
    @(negedge clk);
    rst = 1'b0; ram_clr = 1'b0;

    // full-word write then read back
    txn(0, 1'b1, 32'h0000_1008, 32'hDEAD_BEEF, 4'hF);
    txn(0, 1'b0, 32'h0000_1008, 32'h0, 4'h0);
    // byte write into word 1
    txn(0, 1'b1, 32'h0000_1004, 32'h1122_3344, 4'hF);
    txn(0, 1'b1, 32'h0000_1005, 32'h0000_00AA, 4'b0010);
    txn(0, 1'b0, 32'h0000_1004, 32'h0, 4'h0);
    // empty mask write changes nothing
    txn(1, 1'b1, 32'h0000_1004, 32'hFFFF_FFFF, 4'h0);
    txn(1, 1'b0, 32'h0000_1004, 32'h0, 4'h0);
    // window edges
    txn(1, 1'b1, 32'h0001_0FFC, 32'hCAFE_F00D, 4'hF);
    txn(1, 1'b0, 32'h0001_0FFC, 32'h0, 4'h0);
    txn(0, 1'b0, 32'h0000_1000, 32'h0, 4'h0);
    // out of window
    txn(1, 1'b0, 32'h0000_0FFC, 32'h0, 4'h0);
    txn(1, 1'b0, TOP, 32'h0, 4'h0);
    txn(1, 1'b1, TOP, 32'h1234_5678, 4'hF);
    txn(0, 1'b0, 32'h0000_0FFC, 32'h0, 4'h0);
    txn(0, 1'b1, 32'h0000_0000, 32'h5555_5555, 4'hF);
    // random in-window traffic
    for (int i = 0; i < 8; i++) begin
      a  = BASE + (32'($urandom_range(0, 15)) << 2);
      d  = $urandom;
      wm = 4'($urandom_range(0, 15));
      txn($urandom_range(0, 1), 1'($urandom_range(0, 1)), a, d, wm);
    end
    // contention rounds
    for (int r = 0; r < 4; r++) both_reads(32'h0000_1008, 32'h0000_1004 + 32'(r * 4));

    // reset in CAPTURE
    drive(0, 1'b1, 1'b0, 32'h0000_1008, 32'h0, 4'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_capture", state_dbg, CAPTURE);
    rst = 1'b1;
    #1;
    m0_req = 1'b0;
    chk("mid_rst_state", state_dbg, IDLE);
    chk("mid_rst_acks", {m0_ack, m1_ack, m0_err, m1_err}, 4'h0);
    chk("mid_rst_mem", {mem_wren, mem_addr, mem_wdata, mem_mask}, '0);
    chk("mid_rst_rdata", {m0_rdata, m1_rdata}, 64'h0);
    last_rd0 = '0; last_rd1 = '0; tb_last = 1;
    @(posedge clk); #1;
    chk("rst_hold_ack", {m0_ack, m1_ack}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    txn(0, 1'b0, 32'h0000_1008, 32'h0, 4'h0);
    txn(1, 1'b0, 32'h0001_0FFC, 32'h0, 4'h0);

    repeat (3) @(posedge clk);
    #2;
    chk("queues_drained", exp_q0.size() + exp_q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
